frame_scheduler: RTL

- Double-buffered frame store and swap sequencer that feeds the cube scan driver's 512-bit frame input.
- Pattern/animation generators write the back buffer byte-by-byte. A swap request is only honoured on a refresh-period boundary, so a frame is never torn mid-scan.
- A minimum hold of HOLD_FRAMES full refreshes per frame is enforced. A one-command clear of the back buffer is provided.
- Sits between animation logic and the scan driver. Shares the scan driver's clock and refresh length.

---
 rtl/frame_scheduler_pkg.sv | 14 +
 rtl/frame_scheduler_refresh_timer.sv | 40 ++++
 rtl/frame_scheduler.sv | 134 +++++++++++++
 3 files changed

// File: rtl/frame_scheduler_pkg.sv
// Shared types and sizes for the frame scheduler and its sub-blocks.
package frame_scheduler_pkg;

  localparam int unsigned CUBE_ROWS = 64;
  localparam int unsigned ROW_W     = 8;
  localparam int unsigned ADDR_W    = 6;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StClear   = 2'd1,
    StPending = 2'd2
  } state_e;

endpackage

// File: rtl/frame_scheduler_refresh_timer.sv
// Free-running refresh counter plus a saturating count of completed refreshes
// since the last swap.
module frame_scheduler_refresh_timer #(
  parameter int unsigned LEN         = 14,
  parameter int unsigned HOLD_FRAMES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_hold_clr,
  output logic       o_boundary,
  output logic [7:0] o_hold_cnt
);

  logic [LEN-1:0] r_cnt;
  logic [7:0]     r_hold_cnt;

  assign o_boundary = &r_cnt;
  assign o_hold_cnt = r_hold_cnt;

  // Refresh counter: wraps every 2^LEN cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + LEN'(1);
    end
  end

  // Completed refreshes; a swap clears it even when it lands on a boundary.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold_cnt <= '0;
    end else if (i_hold_clr) begin
      r_hold_cnt <= '0;
    end else if (o_boundary && (r_hold_cnt < 8'(HOLD_FRAMES))) begin
      r_hold_cnt <= r_hold_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/frame_scheduler.sv
// Double-buffered 64x8 frame store with boundary-aligned swap and back-buffer clear.
module frame_scheduler
  import frame_scheduler_pkg::*;
#(
  parameter int unsigned LEN         = 14,
  parameter int unsigned HOLD_FRAMES = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_wr_en,
  input  logic [ADDR_W-1:0]          i_wr_addr,
  input  logic [ROW_W-1:0]           i_wr_data,
  output logic                       o_wr_ready,
  input  logic                       i_clr_req,
  input  logic                       i_swap_req,
  output logic                       o_swap_ack,
  output logic                       o_busy,
  output logic                       o_frame_tick,
  output logic [CUBE_ROWS*ROW_W-1:0] o_frame_cube_flat
);

  state_e            r_state;
  logic [ADDR_W-1:0] r_clr_addr;
  logic              r_front_sel;
  logic              r_swap_ack;
  logic [ROW_W-1:0]  r_buf0 [CUBE_ROWS];
  logic [ROW_W-1:0]  r_buf1 [CUBE_ROWS];

  logic              w_boundary;
  logic [7:0]        w_hold_cnt;
  logic              w_hold_ok;
  logic              w_swap_fire;
  logic              w_wr_ready;
  logic              w_bk_en;
  logic [ADDR_W-1:0] w_bk_addr;
  logic [ROW_W-1:0]  w_bk_data;

  frame_scheduler_refresh_timer #(
    .LEN         (LEN),
    .HOLD_FRAMES (HOLD_FRAMES)
  ) u_refresh_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_hold_clr (w_swap_fire),
    .o_boundary (w_boundary),
    .o_hold_cnt (w_hold_cnt)
  );

  // Swap is allowed if this boundary completes the required number of refreshes.
  assign w_hold_ok   = ({1'b0, w_hold_cnt} + 9'd1) >= 9'(HOLD_FRAMES);
  assign w_swap_fire = (r_state == StPending) && w_boundary && w_hold_ok;
  // Gated by reset so every output reads zero while reset is held.
  assign w_wr_ready  = (r_state == StIdle) && i_rst_n;

  assign o_wr_ready   = w_wr_ready;
  assign o_swap_ack   = r_swap_ack;
  assign o_busy       = (r_state != StIdle);
  assign o_frame_tick = w_boundary;

  // Single back-buffer write port shared by user writes and the clear sweep.
  always_comb begin
    w_bk_en   = 1'b0;
    w_bk_addr = i_wr_addr;
    w_bk_data = i_wr_data;
    if (r_state == StClear) begin
      w_bk_en   = 1'b1;
      w_bk_addr = r_clr_addr;
      w_bk_data = '0;
    end else if (i_wr_en && w_wr_ready) begin
      w_bk_en = 1'b1;
    end
  end

  // Buffer storage: only the buffer not on display is ever written.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < CUBE_ROWS; i++) begin
        r_buf0[i] <= '0;
        r_buf1[i] <= '0;
      end
    end else if (w_bk_en) begin
      if (r_front_sel) begin
        r_buf0[w_bk_addr] <= w_bk_data;
      end else begin
        r_buf1[w_bk_addr] <= w_bk_data;
      end
    end
  end

  // Sequencer: clear sweep, swap wait, front select and ack pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_clr_addr  <= '0;
      r_front_sel <= 1'b0;
      r_swap_ack  <= 1'b0;
    end else begin
      r_swap_ack <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_clr_req) begin
            r_state    <= StClear;
            r_clr_addr <= '0;
          end else if (i_swap_req) begin
            r_state <= StPending;
          end
        end
        StClear: begin
          r_clr_addr <= r_clr_addr + ADDR_W'(1);
          if (r_clr_addr == ADDR_W'(CUBE_ROWS - 1)) begin
            r_state <= StIdle;
          end
        end
        StPending: begin
          if (w_swap_fire) begin
            r_front_sel <= ~r_front_sel;
            r_swap_ack  <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Front buffer flattened straight onto the scan driver bus.
  always_comb begin
    o_frame_cube_flat = '0;
    for (int i = 0; i < CUBE_ROWS; i++) begin
      o_frame_cube_flat[ROW_W*i +: ROW_W] = r_front_sel ? r_buf1[i] : r_buf0[i];
    end
  end

endmodule
